seq_tx_loader: RTL and testbench



---
 rtl/seq_tx_loader_pkg.sv | 25 ++
 rtl/seq_tx_loader_if.sv | 24 ++
 rtl/seq_tx_loader.sv | 114 +++++++++++
 tb/tb_seq_tx_loader.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seq_tx_loader_pkg.sv
// Shared definitions for the sequence transmit path: loader states and
// nucleotide character codes, also used by the UART-side encoder.
package seq_tx_loader_pkg;

    localparam int CHAR_W      = 3;
    localparam int SEQ_MAX_LEN = 16;
    localparam int SEQ_ADDR_W  = 4;
    localparam int SEQ_LEN_W   = 5;

    localparam logic [CHAR_W-1:0] CODE_A    = 3'd0;
    localparam logic [CHAR_W-1:0] CODE_C    = 3'd1;
    localparam logic [CHAR_W-1:0] CODE_G    = 3'd2;
    localparam logic [CHAR_W-1:0] CODE_T    = 3'd3;
    localparam logic [CHAR_W-1:0] TERM_CODE = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_TERM  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/seq_tx_loader_if.sv
// Loader-side bus: sequence memory read port plus transmit FIFO write port.
interface seq_tx_loader_if
    import seq_tx_loader_pkg::*;
#(
    parameter int AW = SEQ_ADDR_W,
    parameter int CW = CHAR_W
);
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data;
    logic          fifo_full;
    logic          wr;
    logic [CW-1:0] data;

    modport master (
        output rd_en, rd_addr, wr, data,
        input  rd_data, fifo_full
    );

    modport slave (
        input  rd_en, rd_addr, wr, data,
        output rd_data, fifo_full
    );
endinterface

// File: rtl/seq_tx_loader.sv
// Streams a stored sequence from memory into a UART transmit FIFO, followed
// by a terminator code, stalling on FIFO back-pressure.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; len latched and clamped on accept
// S_ADDR  | read request for character idx is on the memory port
// S_CAPT  | memory data captured into char_q
// S_WRITE | char_q offered to FIFO; held while fifo_full
// S_TERM  | terminator offered to FIFO; held while fifo_full
// S_DONE  | one-cycle done pulse, then back to idle
module seq_tx_loader
    import seq_tx_loader_pkg::*;
#(
    parameter int MAX_LEN = SEQ_MAX_LEN,
    parameter int ADDR_W  = SEQ_ADDR_W,
    parameter int LEN_W   = SEQ_LEN_W
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [LEN_W-1:0]     i_len,
    seq_tx_loader_if.master      bus,
    output logic                 o_busy,
    output logic                 o_done
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [LEN_W-1:0]    r_len_q;
    logic [CHAR_W-1:0]   r_char_q;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_busy;
    logic                r_done;

    logic [LEN_W-1:0]    w_len_clamp;
    logic                w_last;
    logic                w_wr;

    assign w_len_clamp = (i_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_len;
    assign w_last      = (LEN_W'(r_idx) == (r_len_q - LEN_W'(1)));

    // Write strobe is qualified by fifo_full directly so a full FIFO never sees a write.
    assign w_wr = ((r_state == S_WRITE) || (r_state == S_TERM)) && !bus.fifo_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_len_q   <= '0;
            r_char_q  <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len_q <= w_len_clamp;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        if (w_len_clamp == '0) begin
                            r_state <= S_TERM;
                        end else begin
                            r_state   <= S_ADDR;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= '0;
                        end
                    end
                end
                S_ADDR: r_state <= S_CAPT;
                S_CAPT: begin
                    r_char_q <= bus.rd_data;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    if (!bus.fifo_full) begin
                        if (w_last) begin
                            r_state <= S_TERM;
                        end else begin
                            r_idx     <= r_idx + ADDR_W'(1);
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= r_idx + ADDR_W'(1);
                            r_state   <= S_ADDR;
                        end
                    end
                end
                S_TERM: begin
                    if (!bus.fifo_full) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_en   = r_rd_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.wr      = w_wr;
    assign bus.data    = (r_state == S_TERM) ? TERM_CODE : r_char_q;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_seq_tx_loader.sv
// Directed bench for seq_tx_loader: cycle-exact output checks per run plus
// end-of-run write/read/done tallies.
module tb_seq_tx_loader;
    import seq_tx_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] len;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_tx_loader_if #(.AW(4), .CW(3)) bus ();

    seq_tx_loader dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_len   (len),
        .bus     (bus),
        .o_busy  (busy),
        .o_done  (done)
    );

    // Synchronous-read sequence memory
    logic [2:0] mem [16];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    // Running tallies of bus activity; runs compare against a baseline.
    int         wr_cnt   = 0;
    int         done_cnt = 0;
    int         rd_cnt   = 0;
    int         ovf_cnt  = 0;
    int         lim      = 15;
    logic [2:0] wlog [256];

    always @(posedge clk) begin
        if (bus.wr === 1'b1) begin
            wlog[wr_cnt[7:0]] <= bus.data;
            wr_cnt <= wr_cnt + 1;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.rd_en === 1'b1) begin
            rd_cnt <= rd_cnt + 1;
            if (int'(bus.rd_addr) > lim) ovf_cnt <= ovf_cnt + 1;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs in cycle m after start accepted, no back-pressure.
    task automatic exp_at(input int m, input int lq, output logic ewr, output logic [2:0] ed,
                          output logic chk_d, output logic erd, output logic [3:0] ea,
                          output logic eb, output logic edn);
        int last;
        last  = 3 * lq + 2;
        eb    = (m <= last);
        edn   = (m == last);
        ewr   = 1'b0;
        ed    = 3'd0;
        chk_d = 1'b0;
        if (m >= 3 && m <= 3 * lq && (m % 3) == 0) begin
            ewr = 1'b1; ed = mem[m / 3 - 1]; chk_d = 1'b1;
        end else if (m == 3 * lq + 1) begin
            ewr = 1'b1; ed = 3'b111; chk_d = 1'b1;
        end
        erd = (m >= 1 && m <= 3 * lq - 2 && (m % 3) == 1);
        ea  = 4'((m - 1) / 3);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, " wr"},      32'(bus.wr),      32'd0);
        chk({tag, " rd_en"},   32'(bus.rd_en),   32'd0);
        chk({tag, " rd_addr"}, 32'(bus.rd_addr), 32'd0);
        chk({tag, " data"},    32'(bus.data),    32'd0);
        chk({tag, " busy"},    32'(busy),        32'd0);
        chk({tag, " done"},    32'(done),        32'd0);
    endtask

    // One run: len_in applied, lq = expected latched length, FIFO full for n
    // cycles from cycle s, extra start at cycle rs_c, reset at cycle ab_c.
    task automatic run(string tag, int len_in, int lq, int s, int n, int rs_c, int ab_c);
        int b_wr, b_done, b_rd, b_ovf, nc, m, nw;
        logic ewr, chk_d, erd, eb, edn;
        logic [2:0] ed;
        logic [3:0] ea;
        b_wr = wr_cnt; b_done = done_cnt; b_rd = rd_cnt; b_ovf = ovf_cnt;
        lim  = lq - 1;
        len  = 5'(len_in);
        start = 1'b1;
        step();
        start = 1'b0;
        nc = 3 * lq + 2 + n + 1;
        for (int c = 1; c <= nc; c++) begin
            bus.fifo_full = (n > 0 && c >= s && c < s + n);
            start = (c == rs_c);
            if (c == ab_c) rst = 1'b1;
            #1;
            if (n > 0 && c >= s && c < s + n) begin
                exp_at(s, lq, ewr, ed, chk_d, erd, ea, eb, edn);
                ewr = 1'b0;
            end else begin
                m = (n > 0 && c >= s + n) ? c - n : c;
                exp_at(m, lq, ewr, ed, chk_d, erd, ea, eb, edn);
            end
            chk($sformatf("%s c%0d wr", tag, c), 32'(bus.wr), 32'(ewr));
            if (chk_d) chk($sformatf("%s c%0d data", tag, c), 32'(bus.data), 32'(ed));
            chk($sformatf("%s c%0d rd_en", tag, c), 32'(bus.rd_en), 32'(erd));
            if (erd) chk($sformatf("%s c%0d rd_addr", tag, c), 32'(bus.rd_addr), 32'(ea));
            chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(eb));
            chk($sformatf("%s c%0d done", tag, c), 32'(done), 32'(edn));
            step();
            if (c == ab_c) begin
                start = 1'b0;
                rst = 1'b0;
                #1;
                chk_reset_outputs({tag, " after rst"});
                nw = (ab_c / 3 < lq) ? ab_c / 3 : lq;
                chk({tag, " writes before rst"}, 32'(wr_cnt - b_wr), 32'(nw));
                return;
            end
        end
        start = 1'b0;
        bus.fifo_full = 1'b0;
        chk({tag, " write count"}, 32'(wr_cnt - b_wr), 32'(lq + 1));
        chk({tag, " done count"},  32'(done_cnt - b_done), 32'd1);
        chk({tag, " read count"},  32'(rd_cnt - b_rd), 32'(lq));
        chk({tag, " addr range"},  32'(ovf_cnt - b_ovf), 32'd0);
        for (int i = 0; i < lq; i++)
            chk($sformatf("%s char %0d", tag, i), 32'(wlog[(b_wr + i) % 256]), 32'(mem[i]));
        chk({tag, " terminator"}, 32'(wlog[(b_wr + lq) % 256]), 32'd7);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = (i < 4) ? 3'(i) : 3'(i % 7);
        rst = 1'b1;
        start = 1'b0;
        len = 5'd0;
        bus.fifo_full = 1'b0;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        run("basic",   4,  4, 0, 0, 0, 0);
        run("stall",   4,  4, 6, 3, 0, 0);
        run("len0",    0,  0, 0, 0, 0, 0);
        run("clamp",   20, 16, 0, 0, 0, 0);
        run("restart", 4,  4, 0, 0, 5, 0);
        run("abort",   4,  4, 0, 0, 0, 7);
        run("len2",    2,  2, 0, 0, 0, 0);
        run("tstall",  2,  2, 7, 2, 0, 0);
        run("len16",   16, 16, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
